// File: rtl/raster_tile_fetch_pkg.sv
// Shared types for the raster tile fetch front end.
//   raster_dcrs_t  : fetch configuration (tile buffer base, tile count, destination size)
//   raster_tile_t  : tile descriptor handed to the tile rasterizer
//   fetch_state_t  : fetch controller states
//   unpack_tile_rec: maps the low 48 bits of an 8-byte tile record onto a raster_tile_t
package raster_tile_fetch_pkg;

    localparam int RASTER_TILE_BITS      = 16;
    localparam int RASTER_PID_BITS       = 16;
    localparam int RASTER_TILE_REC_BYTES = 8;
    localparam int RASTER_CNT_BITS       = RASTER_TILE_BITS + 1;

    typedef struct packed {
        logic [31:0]                 tbuf_addr;
        logic [RASTER_TILE_BITS-1:0] tile_count;
        logic [15:0]                 dst_width;
        logic [15:0]                 dst_height;
    } raster_dcrs_t;

    typedef struct packed {
        logic [RASTER_TILE_BITS-1:0] tile_x;
        logic [RASTER_TILE_BITS-1:0] tile_y;
        logic [RASTER_PID_BITS-1:0]  pid;
    } raster_tile_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_t;

    // Record layout: [15:0] tile_x, [31:16] tile_y, [PID+31:32] pid.
    function automatic raster_tile_t unpack_tile_rec(input logic [RASTER_PID_BITS+31:0] rec);
        raster_tile_t t;
        t.tile_x = rec[15:0];
        t.tile_y = rec[31:16];
        t.pid    = rec[RASTER_PID_BITS+31:32];
        return t;
    endfunction

endpackage

// File: rtl/raster_tile_fetch_rob.sv
// Reorder buffer for tile records.
// Slots are allocated in order at the tail when a read is issued, filled out of
// order by tagged responses, and released in order from the head.
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   alloc               read request fired: mark slot[tail] pending, advance tail
//   tail, tail_free     current tail index and whether that slot can be allocated
//   fill_valid/tag/data response write into slot[fill_tag]
//   head_filled/data    head slot status and contents
//   head_release        head slot consumed: free it, advance head
module raster_tile_rob
    import raster_tile_fetch_pkg::*;
#(
    parameter int NUM_SLOTS = 4,
    parameter int TAG_WIDTH = $clog2(NUM_SLOTS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 alloc,
    output logic [TAG_WIDTH-1:0] tail,
    output logic                 tail_free,
    input  logic                 fill_valid,
    input  logic [TAG_WIDTH-1:0] fill_tag,
    input  raster_tile_t         fill_data,
    output logic                 head_filled,
    output raster_tile_t         head_data,
    input  logic                 head_release
);

    logic [TAG_WIDTH-1:0] head_reg;
    logic [TAG_WIDTH-1:0] tail_reg;
    logic [NUM_SLOTS-1:0] pending;
    logic [NUM_SLOTS-1:0] filled;
    raster_tile_t         slot_data [NUM_SLOTS];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
            logic         slot_pending_reg;
            logic         slot_filled_reg;
            raster_tile_t slot_data_reg;
            logic         hit_alloc;
            logic         hit_fill;
            logic         hit_release;

            assign hit_alloc   = alloc && (tail_reg == TAG_WIDTH'(gi));
            assign hit_fill    = fill_valid && (fill_tag == TAG_WIDTH'(gi));
            assign hit_release = head_release && (head_reg == TAG_WIDTH'(gi));

            // A slot is allocated only when neither pending nor filled, and is
            // released only when filled, so alloc/fill/release never collide
            // on the same slot in one cycle.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    slot_pending_reg <= 1'b0;
                    slot_filled_reg  <= 1'b0;
                    slot_data_reg    <= '0;
                end else begin
                    if (hit_alloc) begin
                        slot_pending_reg <= 1'b1;
                    end else if (hit_fill) begin
                        slot_pending_reg <= 1'b0;
                    end
                    if (hit_fill) begin
                        slot_filled_reg <= 1'b1;
                        slot_data_reg   <= fill_data;
                    end else if (hit_release) begin
                        slot_filled_reg <= 1'b0;
                    end
                end
            end

            assign pending[gi]   = slot_pending_reg;
            assign filled[gi]    = slot_filled_reg;
            assign slot_data[gi] = slot_data_reg;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_reg <= '0;
            tail_reg <= '0;
        end else begin
            if (alloc) begin
                tail_reg <= tail_reg + 1'b1;
            end
            if (head_release) begin
                head_reg <= head_reg + 1'b1;
            end
        end
    end

    // Status comes from registered bits only, so a slot released this cycle
    // becomes allocatable next cycle.
    assign tail        = tail_reg;
    assign tail_free   = !pending[tail_reg] && !filled[tail_reg];
    assign head_filled = filled[head_reg];
    assign head_data   = slot_data[head_reg];

    a_fill_pending : assert property (@(posedge clk) disable iff (!reset)
        fill_valid |-> pending[fill_tag]);

endmodule

// File: rtl/raster_tile_fetch.sv
// Raster tile fetch: walks the tile buffer, issues one 8-byte read per tile
// record (up to NUM_SLOTS in flight), reorders responses and emits tile
// descriptors in buffer order.
// Optional feature macro: RASTER_TILE_CULL_EN -- drops tiles whose pixel origin
// lies outside dst_width/dst_height; such tiles retire without tile_valid.
// Ports:
//   clk, reset                  clock, asynchronous active-low reset
//   start, dcrs                 start pulse and configuration (sampled on accepted start)
//   busy, done                  fetch in progress, one-cycle completion pulse
//   mem_req_*                   read request channel (tag = reorder slot)
//   mem_rsp_*                   read response channel (always accepted)
//   tile_valid/data/ready       descriptor output stream
module raster_tile_fetch
    import raster_tile_fetch_pkg::*;
#(
    parameter int TILE_LOGSIZE = 5,
    parameter int NUM_SLOTS    = 4,
    parameter int TAG_WIDTH    = $clog2(NUM_SLOTS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  raster_dcrs_t         dcrs,
    output logic                 busy,
    output logic                 done,
    output logic                 mem_req_valid,
    output logic [31:0]          mem_req_addr,
    output logic [TAG_WIDTH-1:0] mem_req_tag,
    input  logic                 mem_req_ready,
    input  logic                 mem_rsp_valid,
    input  logic [63:0]          mem_rsp_data,
    input  logic [TAG_WIDTH-1:0] mem_rsp_tag,
    output logic                 mem_rsp_ready,
    output logic                 tile_valid,
    output raster_tile_t         tile_data,
    input  logic                 tile_ready
);

    fetch_state_t               state_reg;
    fetch_state_t               state_next;
    logic [31:0]                tbuf_addr_reg;
    logic [RASTER_CNT_BITS-1:0] tile_count_reg;
    logic [RASTER_CNT_BITS-1:0] issue_cnt_reg;
    logic [RASTER_CNT_BITS-1:0] retire_cnt_reg;
    logic                       done_reg;

    logic         start_accept;
    logic         req_fire;
    logic         tail_free;
    logic         head_filled;
    logic         head_culled;
    logic         head_release;
    logic         last_issue;
    logic         last_retire;
    raster_tile_t head_data;

    assign start_accept = start && (state_reg == ST_IDLE);
    assign req_fire     = mem_req_valid && mem_req_ready;
    assign head_release = (tile_valid && tile_ready) || (head_filled && head_culled);
    assign last_issue   = req_fire && ((issue_cnt_reg + 1'b1) == tile_count_reg);
    assign last_retire  = head_release && ((retire_cnt_reg + 1'b1) == tile_count_reg);

    raster_tile_rob #(
        .NUM_SLOTS (NUM_SLOTS),
        .TAG_WIDTH (TAG_WIDTH)
    ) u_rob (
        .clk          (clk),
        .reset        (reset),
        .alloc        (req_fire),
        .tail         (mem_req_tag),
        .tail_free    (tail_free),
        .fill_valid   (mem_rsp_valid),
        .fill_tag     (mem_rsp_tag),
        .fill_data    (unpack_tile_rec(mem_rsp_data[RASTER_PID_BITS+31:0])),
        .head_filled  (head_filled),
        .head_data    (head_data),
        .head_release (head_release)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; an empty job never leaves IDLE.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (start && (dcrs.tile_count != '0)) state_next = ST_FETCH;
            ST_FETCH: if (last_issue)  state_next = ST_DRAIN;
            ST_DRAIN: if (last_retire) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        busy          = (state_reg != ST_IDLE);
        done          = done_reg;
        mem_req_valid = (state_reg == ST_FETCH) && tail_free && (issue_cnt_reg < tile_count_reg);
        mem_req_addr  = tbuf_addr_reg + (32'(issue_cnt_reg) << $clog2(RASTER_TILE_REC_BYTES));
        mem_rsp_ready = 1'b1;
        tile_valid    = head_filled && !head_culled;
        tile_data     = head_data;
    end

    // Job counters and latched configuration
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tbuf_addr_reg  <= '0;
            tile_count_reg <= '0;
            issue_cnt_reg  <= '0;
            retire_cnt_reg <= '0;
            done_reg       <= 1'b0;
        end else begin
            done_reg <= (start_accept && (dcrs.tile_count == '0)) || last_retire;
            if (start_accept) begin
                tbuf_addr_reg  <= dcrs.tbuf_addr;
                tile_count_reg <= RASTER_CNT_BITS'(dcrs.tile_count);
                issue_cnt_reg  <= '0;
                retire_cnt_reg <= '0;
            end else begin
                if (req_fire) begin
                    issue_cnt_reg <= issue_cnt_reg + 1'b1;
                end
                if (head_release) begin
                    retire_cnt_reg <= retire_cnt_reg + 1'b1;
                end
            end
        end
    end

    logic unused_rsp_bits;
    assign unused_rsp_bits = ^mem_rsp_data[63:RASTER_PID_BITS+32];

`ifdef RASTER_TILE_CULL_EN
    logic [15:0] dst_width_reg;
    logic [15:0] dst_height_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dst_width_reg  <= '0;
            dst_height_reg <= '0;
        end else if (start_accept) begin
            dst_width_reg  <= dcrs.dst_width;
            dst_height_reg <= dcrs.dst_height;
        end
    end

    // Widen before shifting so large tile coordinates cannot wrap into range.
    assign head_culled = ((32'(head_data.tile_x) << TILE_LOGSIZE) >= 32'(dst_width_reg)) ||
                         ((32'(head_data.tile_y) << TILE_LOGSIZE) >= 32'(dst_height_reg));
`else
    logic unused_cull_cfg;
    assign head_culled     = 1'b0;
    assign unused_cull_cfg = (^{dcrs.dst_width, dcrs.dst_height}) ^ (TILE_LOGSIZE != 0);
`endif

endmodule
